// File: rtl/gf2m_reduce_283_if.sv
// Handshake bundle for the B-283 reduction stage: unreduced product in,
// reduced field element out, plus a busy status flag.
interface gf2m_reduce_283_if;
    localparam int M = 283;

    logic             in_valid;
    logic             in_ready;
    logic [2*M-2:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     out_data;
    logic             busy;

    // Reduction block side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    // Producer / consumer side
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );
endinterface

// File: rtl/gf2m_reduce_283.sv
// Sequential reduction of a 565-bit GF(2) product modulo
// f(x) = x^283 + x^12 + x^7 + x^5 + 1, folding STEP bits per clock
// from the top of the product downwards.
module gf2m_reduce_283 #(
    parameter int STEP = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    gf2m_reduce_283_if.slave bus
);
    localparam int M    = 283;
    localparam int W    = 2 * M - 1;
    localparam int NCYC = (M - 1 + STEP - 1) / STEP;
    localparam int CW   = $clog2(NCYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [M-1:0]    out_data_q, out_data_d;
    logic [W-1:0]    folded;

    // Fold the current chunk acc[hi:lo]: every set bit p is cleared and its
    // image x^(p-283)*(x^12+x^7+x^5+1) is XORed in. All images fall below lo,
    // so the bits inside one chunk never interact and one cycle suffices.
    always_comb begin
        int hi;
        int lo;
        hi = 2 * M - 2 - int'(cnt_q) * STEP;
        lo = hi - STEP + 1;
        if (lo < M) begin
            lo = M;
        end
        folded = acc_q;
        for (int p = M; p < W; p++) begin
            if (p >= lo && p <= hi && acc_q[p]) begin
                folded[p]          = 1'b0;
                folded[p - M]      = folded[p - M]      ^ 1'b1;
                folded[p - M + 5]  = folded[p - M + 5]  ^ 1'b1;
                folded[p - M + 7]  = folded[p - M + 7]  ^ 1'b1;
                folded[p - M + 12] = folded[p - M + 12] ^ 1'b1;
            end
        end
    end

    // Next-state logic: accept in IDLE, fold NCYC chunks, then hold the
    // result until the consumer takes it.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = bus.in_data;
                    cnt_d   = '0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                acc_d = folded;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NCYC - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = folded[M-1:0];
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset drops any
    // product in flight without producing an output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Once folding is complete nothing may remain above degree 282.
    accHighClear: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == DONE) |-> (acc_q[W-1:M] == '0));

endmodule

// File: tb/tb_gf2m_reduce_283.sv
// Self-checking bench for gf2m_reduce_283: three instances at STEP = 32, 1
// and 271 share one clock and reset, each checked against a long-division
// reference model of reduction modulo the B-283 pentanomial.
module tb_gf2m_reduce_283;
    localparam int M  = 283;
    localparam int W  = 2 * M - 1;
    localparam int NI = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   ivR;
    logic [NI-1:0]   ordyR;
    logic [W-1:0]    idR [NI];
    wire  [NI-1:0]   irW;
    wire  [NI-1:0]   ovW;
    wire  [NI-1:0]   bsyW;
    wire  [M-1:0]    odW [NI];

    int passCount  = 0;
    int checkCount = 0;

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : inst
        gf2m_reduce_283_if ifc ();

        assign ifc.in_valid  = ivR[g];
        assign ifc.in_data   = idR[g];
        assign ifc.out_ready = ordyR[g];
        assign irW[g]        = ifc.in_ready;
        assign ovW[g]        = ifc.out_valid;
        assign bsyW[g]       = ifc.busy;
        assign odW[g]        = ifc.out_data;

        gf2m_reduce_283 #(
            .STEP(g == 0 ? 32 : (g == 1 ? 1 : 271))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc.slave)
        );
    end

    function automatic int stepOf(input int g);
        if (g == 0) return 32;
        if (g == 1) return 1;
        return 271;
    endfunction

    function automatic int ncycOf(input int g);
        return (M - 1 + stepOf(g) - 1) / stepOf(g);
    endfunction

    // Polynomial long division by f(x), one quotient bit at a time
    function automatic logic [M-1:0] refMod(input logic [W-1:0] c);
        logic [W-1:0] r;
        logic [W-1:0] f;
        r = c;
        f = '0;
        f[283] = 1'b1;
        f[12]  = 1'b1;
        f[7]   = 1'b1;
        f[5]   = 1'b1;
        f[0]   = 1'b1;
        for (int i = W - 1; i >= M; i--) begin
            if (r[i]) begin
                r = r ^ (f << (i - M));
            end
        end
        return r[M-1:0];
    endfunction

    function automatic logic [W-1:0] randProduct();
        logic [18*32-1:0] t;
        for (int w = 0; w < 18; w++) begin
            t[w*32 +: 32] = $urandom();
        end
        return t[W-1:0];
    endfunction

    // Drive one product into instance g, measure latency, optionally stall
    // the consumer (pulsing in_valid meanwhile) and then hand the result off.
    task automatic applyStimulus(input int g, input logic [W-1:0] data, input int stall,
                                 input bit pulseIv, output logic [M-1:0] res,
                                 output int lat, output bit readyLow, output bit stable);
        int k;
        logic [M-1:0] held;
        readyLow = 1'b1;
        stable   = 1'b1;
        res      = '0;
        lat      = -1;
        k = 0;
        @(negedge clk);
        while (!irW[g] && k < 1000) begin
            @(negedge clk);
            k++;
        end
        ivR[g] = 1'b1;
        idR[g] = data;
        @(posedge clk);
        #1 ivR[g] = 1'b0;
        k = 0;
        while (k < 400) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (irW[g]) readyLow = 1'b0;
            if (ovW[g]) break;
        end
        if (ovW[g]) begin
            lat  = k;
            res  = odW[g];
            held = odW[g];
            for (int s = 0; s < stall; s++) begin
                if (pulseIv) begin
                    ivR[g] = 1'b1;
                    idR[g] = randProduct();
                end
                @(posedge clk);
                @(negedge clk);
                if (!ovW[g] || odW[g] !== held || irW[g]) stable = 1'b0;
            end
            ordyR[g] = 1'b1;
            ivR[g]   = pulseIv;
            @(posedge clk);
            #1;
            ordyR[g] = 1'b0;
            ivR[g]   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ivR   = '0;
        ordyR = '0;
        for (int g = 0; g < NI; g++) idR[g] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checkCount++;
            if (irW[g] !== 1'b1) $display("[TB] FAIL reset_in_ready inst %0d got %b expected 1", g, irW[g]);
            else passCount++;
            checkCount++;
            if (ovW[g] !== 1'b0) $display("[TB] FAIL reset_out_valid inst %0d got %b expected 0", g, ovW[g]);
            else passCount++;
            checkCount++;
            if (bsyW[g] !== 1'b0) $display("[TB] FAIL reset_busy inst %0d got %b expected 0", g, bsyW[g]);
            else passCount++;
            checkCount++;
            if (odW[g] !== '0) $display("[TB] FAIL reset_out_data inst %0d got %h expected 0", g, odW[g]);
            else passCount++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        logic [M-1:0] res;
        int lat;
        bit rl, st;
        applyStimulus(0, W'(1), 0, 1'b0, res, lat, rl, st);
        checkCount++;
        if (res !== M'(1)) $display("[TB] FAIL identity_result got %h expected 1", res);
        else passCount++;
        checkCount++;
        if (lat !== 9) $display("[TB] FAIL identity_latency got %0d expected 9", lat);
        else passCount++;
        checkCount++;
        if (rl !== 1'b1) $display("[TB] FAIL identity_in_ready_low got %b expected 1", rl);
        else passCount++;
    endtask

    task automatic test_single_tap();
        logic [M-1:0] res;
        int lat;
        bit rl, st;
        applyStimulus(0, W'(1) << 283, 0, 1'b0, res, lat, rl, st);
        checkCount++;
        if (res !== M'(16'h10A1)) $display("[TB] FAIL single_tap got %h expected 10a1", res);
        else passCount++;
    endtask

    task automatic test_top_bit();
        logic [M-1:0] res;
        logic [M-1:0] expv;
        int lat;
        bit rl, st;
        expv = '0;
        expv[281] = 1'b1;
        expv[22]  = 1'b1;
        expv[12]  = 1'b1;
        expv[10]  = 1'b1;
        expv[8]   = 1'b1;
        expv[5]   = 1'b1;
        expv[3]   = 1'b1;
        applyStimulus(0, W'(1) << 564, 0, 1'b0, res, lat, rl, st);
        checkCount++;
        if (res !== expv) $display("[TB] FAIL top_bit got %h expected %h", res, expv);
        else passCount++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        logic [M-1:0] res;
        int lat;
        bit rl, st;
        d = randProduct();
        applyStimulus(0, d, 5, 1'b1, res, lat, rl, st);
        checkCount++;
        if (st !== 1'b1) $display("[TB] FAIL backpressure_stable got %b expected 1", st);
        else passCount++;
        checkCount++;
        if (res !== refMod(d)) $display("[TB] FAIL backpressure_result got %h expected %h", res, refMod(d));
        else passCount++;
        checkCount++;
        if (lat !== 9) $display("[TB] FAIL backpressure_latency got %0d expected 9", lat);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (bsyW[0] !== 1'b0 || irW[0] !== 1'b1)
            $display("[TB] FAIL handoff_no_accept got busy=%b in_ready=%b expected busy=0 in_ready=1", bsyW[0], irW[0]);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        logic [M-1:0] res;
        int lat;
        bit rl, st;
        applyStimulus(0, W'(1) << 300, 0, 1'b0, res, lat, rl, st);
        @(negedge clk);
        ivR[0] = 1'b1;
        idR[0] = randProduct();
        @(posedge clk);
        #1 ivR[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (ovW[0] !== 1'b0) $display("[TB] FAIL midreset_out_valid got %b expected 0", ovW[0]);
        else passCount++;
        checkCount++;
        if (bsyW[0] !== 1'b0) $display("[TB] FAIL midreset_busy got %b expected 0", bsyW[0]);
        else passCount++;
        checkCount++;
        if (irW[0] !== 1'b1) $display("[TB] FAIL midreset_in_ready got %b expected 1", irW[0]);
        else passCount++;
        checkCount++;
        if (odW[0] !== '0) $display("[TB] FAIL midreset_out_data got %h expected 0", odW[0]);
        else passCount++;
        rst_n = 1'b1;
        d = randProduct();
        applyStimulus(0, d, 1, 1'b0, res, lat, rl, st);
        checkCount++;
        if (res !== refMod(d)) $display("[TB] FAIL midreset_followup got %h expected %h", res, refMod(d));
        else passCount++;
    endtask

    task automatic test_random(input int g, input int n);
        logic [W-1:0] d;
        logic [M-1:0] res;
        int lat;
        bit rl, st;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? {W{1'b1}} : randProduct();
            applyStimulus(g, d, $urandom_range(0, 3), 1'b0, res, lat, rl, st);
            checkCount++;
            if (res !== refMod(d))
                $display("[TB] FAIL random_result step %0d txn %0d got %h expected %h", stepOf(g), i, res, refMod(d));
            else passCount++;
            checkCount++;
            if (lat !== ncycOf(g))
                $display("[TB] FAIL random_latency step %0d txn %0d got %0d expected %0d", stepOf(g), i, lat, ncycOf(g));
            else passCount++;
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_identity();
        test_single_tap();
        test_top_bit();
        test_backpressure();
        test_reset_mid();
        test_random(0, 100);
        test_random(2, 100);
        test_random(1, 20);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard stop in case a handshake never completes
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog timeout after %0d checks", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
